// File: rtl/cpuregs_pkg.sv
// Shared types and helpers for the general-register access sequencer:
// state/op encodings, mode and register constants, file address forming.
package cpuregs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WB   = 3'd2,
    ST_RSP  = 3'd3,
    ST_CON  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_POSTINC = 2'b10,
    OP_PREDEC  = 2'b11
  } op_t;

  localparam logic [1:0] MODE_KERNEL = 2'b00;
  localparam logic [1:0] MODE_SUPER  = 2'b01;
  localparam logic [1:0] MODE_USER   = 2'b11;

  localparam logic [2:0] REG_SP = 3'd6;
  localparam logic [2:0] REG_PC = 3'd7;

  // The reserved mode 2'b10 shares the user bank.
  function automatic logic [5:0] make_addr(input logic [1:0] mode, input logic rs,
                                           input logic [2:0] rn);
    logic [1:0] m;
    m = (mode == 2'b10) ? MODE_USER : mode;
    return {m, rs, rn};
  endfunction

endpackage

// File: rtl/cpuregs_seq.sv
// Register-file access sequencer: CPU read/write/autoinc/autodec requests
// with mode-banked addressing, plus an arbitrated raw console port.
module cpuregs_seq
  import cpuregs_pkg::*;
#(
  parameter int CON_FAIR = 1,
  parameter int STEP_W   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  psw_cm,
  input  logic [1:0]  psw_pm,
  input  logic        psw_rs,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [2:0]  req_reg,
  input  logic        req_prev,
  input  logic        req_byte,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [5:0]  rf_raddr,
  output logic [5:0]  rf_waddr,
  output logic [15:0] rf_d,
  output logic        rf_we,
  input  logic [15:0] rf_o,
  input  logic        con_req,
  input  logic        con_we,
  input  logic [5:0]  con_addr,
  input  logic [15:0] con_wdata,
  output logic        con_ack,
  output logic [15:0] con_rdata
);

  state_t      state;
  op_t         op;
  logic [15:0] step;
  logic [15:0] res;
  logic        fair;

  logic        idle;
  logic        con_live;
  logic        con_grant;
  logic [1:0]  req_mode;
  logic [5:0]  req_addr;
  logic [15:0] req_step;
  logic [15:0] upd;

  // Arbitration, address/step forming and the autoinc/autodec adder.
  always_comb begin
    idle     = (state == ST_IDLE);
    // A request already acknowledged this cycle is not re-granted.
    con_live = con_req && !con_ack;
    if (!idle || !con_live) begin
      con_grant = 1'b0;
    end else if ((CON_FAIR != 0) && fair) begin
      con_grant = 1'b1;
    end else begin
      con_grant = !req_valid;
    end
    req_ready = idle && !con_grant;
    req_mode  = req_prev ? psw_pm : psw_cm;
    req_addr  = make_addr(req_mode, psw_rs, req_reg);
    req_step  = (req_byte && (req_reg != REG_SP)) ? 16'd1 : 16'(STEP_W);
    if (op == OP_POSTINC) begin
      upd = rf_o + step;
    end else begin
      upd = rf_o - step;
    end
  end

  // Sequencer state, file drive and response/console outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op        <= OP_READ;
      step      <= 16'd0;
      res       <= 16'd0;
      fair      <= 1'b0;
      rf_raddr  <= 6'd0;
      rf_waddr  <= 6'd0;
      rf_d      <= 16'd0;
      rf_we     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'd0;
      rsp_err   <= 1'b0;
      con_ack   <= 1'b0;
      con_rdata <= 16'd0;
    end else begin
      rf_we     <= 1'b0;
      rsp_valid <= 1'b0;
      con_ack   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (con_grant) begin
            fair     <= 1'b0;
            rf_raddr <= con_addr;
            rf_waddr <= con_addr;
            rf_we    <= con_we;
            rf_d     <= con_wdata;
            state    <= ST_CON;
          end else if (req_valid) begin
            if (con_live) begin
              fair <= 1'b1;
            end
            op       <= op_t'(req_op);
            step     <= req_step;
            rf_raddr <= req_addr;
            rf_waddr <= req_addr;
            // R7 lives in the CPU, not in the file.
            if (req_reg == REG_PC) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= 16'd0;
              state     <= ST_RSP;
            end else if (op_t'(req_op) == OP_WRITE) begin
              rf_we <= 1'b1;
              rf_d  <= req_wdata;
              res   <= req_wdata;
              state <= ST_WB;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (op == OP_READ) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= rf_o;
            state     <= ST_RSP;
          end else begin
            rf_we <= 1'b1;
            rf_d  <= upd;
            res   <= (op == OP_POSTINC) ? rf_o : upd;
            state <= ST_WB;
          end
        end
        ST_WB: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= res;
          state     <= ST_RSP;
        end
        ST_RSP: begin
          state <= ST_IDLE;
        end
        ST_CON: begin
          con_ack   <= 1'b1;
          con_rdata <= rf_o;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cpuregs_seq.md
Name: cpuregs_seq

Overview:
- Access sequencer directly upstream of the PDP2011 general-register file; it is the only block driving the file's raddr/waddr/d/we and it consumes its combinational read output.
- Forms 6-bit register-file addresses from PSW mode, previous mode and register-set bits.
- Executes single-register read, write and read-modify-write operations for addressing-mode side effects: (R)+, -(R), SP push/pop.
- Arbitrates a second, console/debug port into the same file.

Parameters:
- CON_FAIR, 1, when 1 a console request refused once wins the next IDLE arbitration.
- STEP_W, 2, word step size; the byte step is fixed at 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- psw_cm  in  2  PSW[15:14], current mode.
- psw_pm  in  2  PSW[13:12], previous mode.
- psw_rs  in  1  PSW[11], register set.
- req_valid  in  1  CPU request.
- req_ready  out  1  CPU request accepted this cycle when high together with req_valid.
- req_op  in  2  00 READ, 01 WRITE, 10 POSTINC, 11 PREDEC.
- req_reg  in  3  register number.
- req_prev  in  1  use psw_pm instead of psw_cm (MFPI/MTPI).
- req_byte  in  1  byte-sized step.
- req_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_data  out  16  response data.
- rsp_err  out  1  request addressed R7.
- rf_raddr  out  6  register-file read address.
- rf_waddr  out  6  register-file write address.
- rf_d  out  16  register-file write data.
- rf_we  out  1  register-file write enable.
- rf_o  in  16  register-file read data, combinational.
- con_req  in  1  console access request, held until con_ack.
- con_we  in  1  console write.
- con_addr  in  6  raw register-file address.
- con_wdata  in  16  console write data.
- con_ack  out  1  one-cycle console completion strobe.
- con_rdata  out  16  console read data.

Behaviour:
- Clocking and reset: one clock, reset synchronous active-low.
- Reset values: state IDLE; rf_we, rsp_valid, rsp_err, con_ack = 0; rf_raddr, rf_waddr, rf_d, rsp_data, con_rdata = 0; fairness flag cleared.
- Reset mid-operation: the sequence is abandoned and no write is issued in the cycle after reset.
- States: IDLE, RD, WB, RSP, CON.
- req_ready = 1 only in IDLE with no console grant that cycle.
- Address latched on accept: addr = {m, psw_rs, req_reg}, where m = req_prev ? psw_pm : psw_cm. Mode 2'b10 is mapped to 2'b11.
- PSW and all req_* inputs are captured on accept; later changes are ignored.
- Step = 2 if req_byte = 0 or req_reg = 6, else 1. Arithmetic is mod 2^16: 16'hFFFF + 1 = 16'h0000, 16'h0000 - 2 = 16'hFFFE.
- Timing, with T = accept cycle:
  - READ: T+1 RD, rf_raddr = addr, rf_o sampled; T+2 RSP, rsp_data = sampled value.
  - WRITE: T+1 WB, rf_we = 1, rf_waddr = addr, rf_d = wdata; T+2 RSP, rsp_data = wdata.
  - POSTINC: T+1 RD; T+2 WB writes old + step; T+3 RSP, rsp_data = old.
  - PREDEC: T+1 RD; T+2 WB writes old - step; T+3 RSP, rsp_data = new.
- req_reg = 7: the PC is not held in the file. T+1 RSP with rsp_err = 1 and rsp_data = 0; no rf_we.
- RSP: rsp_valid = 1 for exactly one cycle, then IDLE. rsp_data/rsp_err hold until the next response.
- Arbitration in IDLE:
  - A CPU req_valid wins over con_req.
  - When CON_FAIR = 1 and the fairness flag is set, the console wins and req_ready = 0 that cycle.
  - The flag is set when con_req is refused and cleared on a console grant.
- CON, one cycle: rf_raddr = rf_waddr = con_addr; rf_we = con_we; rf_d = con_wdata. con_rdata = rf_o registered; con_ack = 1 in the following IDLE cycle.
- The raw console address bypasses mode mapping.
- rf_we is asserted only in WB or CON, never twice per request.

Decomposition:
- Package cpuregs_pkg holds:
  - state encoding;
  - op codes OP_READ/OP_WRITE/OP_POSTINC/OP_PREDEC;
  - mode constants MODE_KERNEL = 2'b00, MODE_SUPER = 2'b01, MODE_USER = 2'b11;
  - REG_SP = 3'd6, REG_PC = 3'd7;
  - the function that forms the 6-bit address from mode, set and register.
- No sub-module; the FSM, step adder and arbiter live in one module.

Test Plan:
- psw_cm = 00, psw_rs = 1, WRITE R3 = 16'h1234, then READ R3 -> rf_waddr = 6'b001011; rsp_data = 16'h1234 at T+2.
- R2 = 16'hFFFF, POSTINC byte R2 -> rsp_data = 16'hFFFF at T+3; R2 = 16'h0000.
- psw_cm = 11, SP = 16'h0000, PREDEC byte R6 -> step forced to 2; rsp_data = 16'hFFFE; rf_waddr = 6'b110110.
- psw_cm = 00, psw_pm = 11, req_prev = 1, READ R6 -> rf_raddr = 6'b110110 and the user SP is returned; with req_prev = 0 the kernel SP is returned.
- READ R7 -> rsp_valid at T+1 with rsp_err = 1, rf_we never asserted.
- con_req held while the CPU issues back-to-back requests -> console refused once, then granted on the next IDLE; con_ack pulses once with the correct con_rdata; rst_n low during a POSTINC WB-1 cycle -> no write occurs and all outputs are 0.
